fpro_to_avalon_master_bridge: RTL and testbench

FPro-bus-to-Avalon-MM master bridge. It lets an FPro-bus initiator (I/O processor core) issue reads and writes into the Avalon fabric. Each FPro request is latched, driven as an Avalon-MM master transaction with full waitrequest/readdatavalid handling, and completed back to the initiator with a done/error pulse and registered read data. A watchdog aborts transactions the fabric never completes.

---
 rtl/fpro_to_avalon_master_bridge.sv | 196 +++++++++++++++++++
 tb/tb_fpro_to_avalon_master_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpro_to_avalon_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : fpro_to_avalon_master_bridge
// Brief    : FPro-bus initiator to Avalon-MM master bridge with watchdog abort.
// Revision : 1.0 - initial release
// ============================================================================
module fpro_to_avalon_master_bridge #(
  parameter logic [31:0] BRG_BASE       = 32'hc000_0000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fp_mmio_cs,
  input  logic        fp_video_cs,
  input  logic        fp_wr,
  input  logic        fp_rd,
  input  logic [20:0] fp_addr,
  input  logic [31:0] fp_wr_data,
  output logic [31:0] fp_rd_data,
  output logic        fp_busy,
  output logic        fp_done,
  output logic        fp_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_t;

  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] c_abort_data   = 32'hDEAD_BEEF;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_rd_data, w_rd_data_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] r_address, w_address_nxt;
  logic        r_read, w_read_nxt;
  logic        r_write, w_write_nxt;
  logic [3:0]  r_be, w_be_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;

  logic w_strobe, w_cs_any, w_cs_both, w_timeout;

  assign w_strobe  = fp_wr | fp_rd;
  assign w_cs_any  = fp_mmio_cs | fp_video_cs;
  assign w_cs_both = fp_mmio_cs & fp_video_cs;
  assign w_timeout = (r_cnt == c_timeout_last);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rd_data_nxt = r_rd_data;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_address_nxt = r_address;
    w_read_nxt    = r_read;
    w_write_nxt   = r_write;
    w_be_nxt      = r_be;
    w_wdata_nxt   = r_wdata;

    case (r_state)
      ST_IDLE: begin
        if (w_strobe && w_cs_both) begin
          w_err_nxt = 1'b1;
        end else if (w_strobe && w_cs_any) begin
          w_address_nxt = {BRG_BASE[31:24], fp_video_cs, fp_addr, 2'b00};
          w_be_nxt      = 4'hF;
          w_cnt_nxt     = 16'd0;
          // Write takes priority when both strobes are raised together.
          if (fp_wr) begin
            w_state_nxt = ST_WR;
            w_write_nxt = 1'b1;
            w_wdata_nxt = fp_wr_data;
          end else begin
            w_state_nxt = ST_RD_REQ;
            w_read_nxt  = 1'b1;
          end
        end
      end

      ST_WR: begin
        if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_write_nxt = 1'b0;
          w_be_nxt    = 4'h0;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end else if (!avm_waitrequest) begin
          w_state_nxt = ST_IDLE;
          w_write_nxt = 1'b0;
          w_be_nxt    = 4'h0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      ST_RD_REQ: begin
        if (w_timeout) begin
          w_state_nxt   = ST_IDLE;
          w_read_nxt    = 1'b0;
          w_be_nxt      = 4'h0;
          w_done_nxt    = 1'b1;
          w_err_nxt     = 1'b1;
          w_rd_data_nxt = c_abort_data;
        end else begin
          if (!avm_waitrequest) begin
            w_state_nxt = ST_RD_WAIT;
            w_read_nxt  = 1'b0;
            w_be_nxt    = 4'h0;
          end
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      ST_RD_WAIT: begin
        if (w_timeout) begin
          w_state_nxt   = ST_IDLE;
          w_done_nxt    = 1'b1;
          w_err_nxt     = 1'b1;
          w_rd_data_nxt = c_abort_data;
        end else if (avm_readdatavalid) begin
          w_state_nxt   = ST_IDLE;
          w_done_nxt    = 1'b1;
          w_rd_data_nxt = avm_readdata;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Requests arriving while a transaction is outstanding are rejected.
    if ((r_state != ST_IDLE) && w_strobe && w_cs_any) begin
      w_err_nxt = 1'b1;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 16'd0;
      r_rd_data <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_address <= 32'd0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_be      <= 4'h0;
      r_wdata   <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_address <= w_address_nxt;
      r_read    <= w_read_nxt;
      r_write   <= w_write_nxt;
      r_be      <= w_be_nxt;
      r_wdata   <= w_wdata_nxt;
    end
  end

  assign fp_rd_data     = r_rd_data;
  assign fp_busy        = r_busy;
  assign fp_done        = r_done;
  assign fp_err         = r_err;
  assign avm_address    = r_address;
  assign avm_read       = r_read;
  assign avm_write      = r_write;
  assign avm_byteenable = r_be;
  assign avm_writedata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_fpro_to_avalon_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpro_to_avalon_master_bridge
// Brief    : Scoreboard bench for the FPro-to-Avalon master bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpro_to_avalon_master_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        fp_mmio_cs, fp_video_cs, fp_wr, fp_rd;
  logic [20:0] fp_addr;
  logic [31:0] fp_wr_data, fp_rd_data;
  logic        fp_busy, fp_done, fp_err;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [3:0]  avm_byteenable;

  always #5 clk = ~clk;

  fpro_to_avalon_master_bridge #(
    .BRG_BASE      (32'hc000_0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fp_mmio_cs       (fp_mmio_cs),
    .fp_video_cs      (fp_video_cs),
    .fp_wr            (fp_wr),
    .fp_rd            (fp_rd),
    .fp_addr          (fp_addr),
    .fp_wr_data       (fp_wr_data),
    .fp_rd_data       (fp_rd_data),
    .fp_busy          (fp_busy),
    .fp_done          (fp_done),
    .fp_err           (fp_err),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_byteenable   (avm_byteenable),
    .avm_writedata    (avm_writedata),
    .avm_readdata     (avm_readdata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
  } cmd_t;

  typedef struct {
    logic        done;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    int          cyc;
  } cpl_t;

  cmd_t cmd_q[$];
  cpl_t cpl_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n, m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: scripted stall count, read latency, stuck mode, late-response injection.
  int          wait_cycles = 0;
  bit          stuck       = 1'b0;
  int          rd_latency  = 1;
  logic [31:0] rd_value    = 32'd0;
  bit          inject      = 1'b0;
  logic [31:0] inject_val  = 32'd0;
  int          stall       = 0;
  int          rdv_cd      = 0;

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      avm_readdatavalid = 1'b0;
      if (!reset) begin
        rdv_cd          = 0;
        stall           = 0;
        avm_waitrequest = 1'b0;
      end else begin
        if (inject) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = inject_val;
          inject            = 1'b0;
        end
        if (rdv_cd > 0) begin
          rdv_cd--;
          if (rdv_cd == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = rd_value;
          end
        end
        if (avm_read || avm_write) begin
          if (stuck || stall < wait_cycles) begin
            avm_waitrequest = 1'b1;
            stall++;
          end else begin
            avm_waitrequest = 1'b0;
            stall           = 0;
            if (avm_read) rdv_cd = rd_latency;
          end
        end else begin
          avm_waitrequest = 1'b0;
          stall           = 0;
        end
      end
    end
  end

  // Monitor: a command is checked when it drops; completions when done/err pulse.
  initial begin : monitor
    int          run;
    logic        last_wr;
    logic [31:0] last_addr, last_data;
    logic [3:0]  last_be;
    cmd_t        ec;
    cpl_t        ep;
    run = 0;
    last_wr = 1'b0; last_addr = '0; last_data = '0; last_be = '0;
    forever begin
      @(negedge clk);
      if (avm_read || avm_write) begin
        run++;
        last_wr   = avm_write;
        last_addr = avm_address;
        last_data = avm_writedata;
        last_be   = avm_byteenable;
      end else if (run != 0) begin
        if (cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_unexpected: got command wr=%0b addr %h expected none", last_wr, last_addr);
        end else begin
          ec = cmd_q.pop_front();
          check("cmd_is_write", {31'd0, last_wr}, {31'd0, ec.wr});
          check("cmd_address", last_addr, ec.addr);
          if (ec.wr) check("cmd_writedata", last_data, ec.data);
          check("cmd_byteenable", {28'd0, last_be}, 32'h0000_000F);
          check("cmd_hold_cycles", run, ec.hold);
        end
        run = 0;
      end
      if (fp_done || fp_err) begin
        if (cpl_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cpl_unexpected: got done=%0b err=%0b expected none", fp_done, fp_err);
        end else begin
          ep = cpl_q.pop_front();
          check("cpl_done", {31'd0, fp_done}, {31'd0, ep.done});
          check("cpl_err", {31'd0, fp_err}, {31'd0, ep.err});
          if (ep.chk_rd) check("cpl_rd_data", fp_rd_data, ep.rd);
          check("cpl_cycle", cyc, ep.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mm, input logic vid, input logic w, input logic r,
                       input logic [20:0] a, input logic [31:0] d);
    fp_mmio_cs  = mm;
    fp_video_cs = vid;
    fp_wr       = w;
    fp_rd       = r;
    fp_addr     = a;
    fp_wr_data  = d;
  endtask

  task automatic exp_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data, input int hold);
    cmd_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.hold = hold;
    cmd_q.push_back(e);
  endtask

  task automatic exp_cpl(input logic done, input logic err, input logic chk,
                         input logic [31:0] rd, input int c);
    cpl_t e;
    e.done = done; e.err = err; e.chk_rd = chk; e.rd = rd; e.cyc = c;
    cpl_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"}, fp_rd_data, 32'd0);
    check({tag, "_busy"}, {31'd0, fp_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, fp_done}, 32'd0);
    check({tag, "_err"}, {31'd0, fp_err}, 32'd0);
    check({tag, "_avm_address"}, avm_address, 32'd0);
    check({tag, "_avm_read"}, {31'd0, avm_read}, 32'd0);
    check({tag, "_avm_write"}, {31'd0, avm_write}, 32'd0);
    check({tag, "_avm_be"}, {28'd0, avm_byteenable}, 32'd0);
    check({tag, "_avm_wdata"}, avm_writedata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) tick();

    // MMIO write, no wait
    n = cyc;
    exp_cmd(1'b1, 32'hC000_0040, 32'h1234_5678, 1);
    exp_cpl(1'b1, 1'b0, 1'b0, 32'd0, n + 2);
    drive(1, 0, 1, 0, 21'h000010, 32'h1234_5678);
    tick();
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    check("wr_busy_n1", {31'd0, fp_busy}, 32'd1);
    repeat (4) tick();

    // Video read, 3 stall cycles, data 2 cycles after accept
    wait_cycles = 3; rd_latency = 2; rd_value = 32'hCAFE_F00D;
    n = cyc;
    exp_cmd(1'b0, 32'hC080_000C, 32'd0, 4);
    exp_cpl(1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, n + 7);
    drive(0, 1, 0, 1, 21'h000003, 32'd0);
    tick();
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    repeat (9) tick();

    // Read with waitrequest stuck: watchdog abort after 8 cycles
    wait_cycles = 0; stuck = 1'b1;
    n = cyc;
    exp_cmd(1'b0, 32'hC000_0014, 32'd0, 8);
    exp_cpl(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, n + 9);
    drive(1, 0, 0, 1, 21'h000005, 32'd0);
    tick();
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    repeat (10) tick();
    stuck = 1'b0;
    inject_val = 32'h1111_1111;
    inject = 1'b1;
    repeat (3) tick();
    check("late_rdv_ignored", fp_rd_data, 32'hDEAD_BEEF);
    check("late_rdv_idle", {31'd0, fp_busy}, 32'd0);

    // Strobe while busy, then both-cs request in IDLE
    wait_cycles = 2;
    n = cyc;
    exp_cpl(1'b0, 1'b1, 1'b0, 32'd0, n + 2);
    exp_cmd(1'b1, 32'hC000_0004, 32'hAAAA_5555, 3);
    exp_cpl(1'b1, 1'b0, 1'b0, 32'd0, n + 4);
    drive(1, 0, 1, 0, 21'h000001, 32'hAAAA_5555);
    tick();
    drive(0, 1, 1, 0, 21'h000007, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    check("busy_kept", {31'd0, fp_busy}, 32'd1);
    check("busy_addr_kept", avm_address, 32'hC000_0004);
    repeat (4) tick();
    wait_cycles = 0;
    m = cyc;
    exp_cpl(1'b0, 1'b1, 1'b0, 32'd0, m + 1);
    drive(1, 1, 0, 1, 21'h000009, 32'd0);
    tick();
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    check("illegal_no_busy", {31'd0, fp_busy}, 32'd0);
    check("illegal_no_read", {31'd0, avm_read}, 32'd0);
    repeat (3) tick();

    // Write and read strobes together: write wins
    n = cyc;
    exp_cmd(1'b1, 32'hC07F_FFFC, 32'h0F0F_0F0F, 1);
    exp_cpl(1'b1, 1'b0, 1'b0, 32'd0, n + 2);
    drive(1, 0, 1, 1, 21'h1FFFFF, 32'h0F0F_0F0F);
    tick();
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    repeat (4) tick();

    // Back-to-back writes, second issued in the done cycle
    n = cyc;
    exp_cmd(1'b1, 32'hC000_0080, 32'h0000_0001, 1);
    exp_cpl(1'b1, 1'b0, 1'b0, 32'd0, n + 2);
    exp_cmd(1'b1, 32'hC000_0084, 32'h0000_0002, 1);
    exp_cpl(1'b1, 1'b0, 1'b0, 32'd0, n + 4);
    drive(1, 0, 1, 0, 21'h000020, 32'h0000_0001);
    tick();
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    tick();
    drive(1, 0, 1, 0, 21'h000021, 32'h0000_0002);
    tick();
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    repeat (4) tick();

    // Reset in RD_WAIT, then a normal write
    rd_latency = 6; rd_value = 32'h5555_AAAA;
    n = cyc;
    exp_cmd(1'b0, 32'hC000_0100, 32'd0, 1);
    drive(1, 0, 0, 1, 21'h000040, 32'd0);
    tick();
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    tick();
    tick();
    check("pre_reset_busy", {31'd0, fp_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    n = cyc;
    exp_cmd(1'b1, 32'hC000_0008, 32'h7777_0001, 1);
    exp_cpl(1'b1, 1'b0, 1'b0, 32'd0, n + 2);
    drive(1, 0, 1, 0, 21'h000002, 32'h7777_0001);
    tick();
    drive(0, 0, 0, 0, 21'd0, 32'd0);
    repeat (8) tick();

    check("cmd_queue_drained", cmd_q.size(), 32'd0);
    check("cpl_queue_drained", cpl_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
